// File: rtl/add_sub_arbiter.sv
// ---------------------------------------------------------------------------
// add_sub_arbiter
//   One shared add/subtract datapath serving NREQ requesters. A round-robin
//   arbiter picks one requester while idle. Its operands are latched and
//   computed in one cycle. The registered response is then held until the
//   consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid && ready are both high. A producer holds valid and payload
// stable until that edge. It may drop valid before a transfer to withdraw.
// ready may depend combinationally on valid.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   reqValid     [NREQ]            per-requester request valid
//   reqA, reqB   [NREQ*INPUTSIZE]  operands, requester i at [i*INPUTSIZE +: INPUTSIZE]
//   reqOp        [NREQ]            0 = a+b, 1 = a-b
//   reqReady     [NREQ]            one-hot accept strobe (IDLE only)
//   rspValid     response valid (RESP state)
//   rspReady     response consumer ready
//   rspId        [IDW]             requester that owns the response
//   rspResult    [INPUTSIZE]       two's-complement result
//   rspOverflow  signed overflow flag
//   busy         high whenever the FSM is not IDLE
//   dbg_state    [2]               current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module add_sub_arbiter #(
  parameter int INPUTSIZE = 4,
  parameter int NREQ      = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           reqValid,
  input  logic [NREQ*INPUTSIZE-1:0] reqA,
  input  logic [NREQ*INPUTSIZE-1:0] reqB,
  input  logic [NREQ-1:0]           reqOp,
  output logic [NREQ-1:0]           reqReady,
  output logic                      rspValid,
  input  logic                      rspReady,
  output logic [IDW-1:0]            rspId,
  output logic [INPUTSIZE-1:0]      rspResult,
  output logic                      rspOverflow,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_found;
  logic                 accept;
  logic [IDW-1:0]       cand;

  logic [INPUTSIZE-1:0] lat_a, lat_b;
  logic                 lat_op;
  logic [IDW-1:0]       lat_id;
  logic [INPUTSIZE-1:0] res;
  logic                 ovf;

  // Round-robin search: first valid requester at or after ptr. NREQ is a
  // power of two, so the IDW-bit addition wraps modulo NREQ for free.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDW'(k);
      if (!grant_found && reqValid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The grant is driven only to a valid requester, so a visible grant is
  // always a transfer.
  assign accept = (state == IDLE) && grant_found && !rst;

  always_comb begin
    reqReady = '0;
    for (int i = 0; i < NREQ; i++) begin
      reqReady[i] = accept && (grant_idx == IDW'(i));
    end
  end

  // Shared datapath. Subtract overflow looks at the original b, so
  // b = most-negative value is still flagged correctly.
  always_comb begin
    res = lat_op ? (lat_a - lat_b) : (lat_a + lat_b);
    if (lat_op) begin
      ovf = (lat_a[INPUTSIZE-1] != lat_b[INPUTSIZE-1]) &&
            (res[INPUTSIZE-1]   != lat_a[INPUTSIZE-1]);
    end else begin
      ovf = (lat_a[INPUTSIZE-1] == lat_b[INPUTSIZE-1]) &&
            (res[INPUTSIZE-1]   != lat_a[INPUTSIZE-1]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rspReady) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rspValid  = (state == RESP);
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Operand latch, round-robin pointer and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_op      <= 1'b0;
      lat_id      <= '0;
      rspResult   <= '0;
      rspOverflow <= 1'b0;
      rspId       <= '0;
    end else begin
      if (accept) begin
        lat_a  <= reqA[int'(grant_idx)*INPUTSIZE +: INPUTSIZE];
        lat_b  <= reqB[int'(grant_idx)*INPUTSIZE +: INPUTSIZE];
        lat_op <= reqOp[grant_idx];
        lat_id <= grant_idx;
        ptr    <= grant_idx + IDW'(1);
      end
      if (state == EXEC) begin
        rspResult   <= res;
        rspOverflow <= ovf;
        rspId       <= lat_id;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
module tb_add_sub_arbiter;
  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int EW  = IDW + 1 + W;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid;
  logic [N*W-1:0] reqA, reqB;
  logic [N-1:0]   reqOp;
  logic [N-1:0]   reqReady;
  logic           rspValid;
  logic           rspReady;
  logic [IDW-1:0] rspId;
  logic [W-1:0]   rspResult;
  logic           rspOverflow;
  logic           busy;
  logic [1:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int grant_cnt [N];

  logic [EW-1:0] exp_q[$];

  add_sub_arbiter #(.INPUTSIZE(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqA(reqA), .reqB(reqB), .reqOp(reqOp),
    .reqReady(reqReady),
    .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId),
    .rspResult(rspResult), .rspOverflow(rspOverflow),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic ovf, input logic [W-1:0] res);
    logic [IDW-1:0] idv;
    idv = IDW'(id);
    exp_q.push_back({idv, ovf, res});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [N-1:0]  acc;
    if (!rst) begin
      if (rspValid && rspReady) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got id=%0d res=%0h ovf=%0b with empty queue",
                   rspId, rspResult, rspOverflow);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rspId, rspOverflow, rspResult} !== exp_v) begin
            n_fail++;
            $display("FAIL rsp_data: got id=%0d ovf=%0b res=%0h expected id=%0d ovf=%0b res=%0h",
                     rspId, rspOverflow, rspResult,
                     exp_v[EW-1 -: IDW], exp_v[W], exp_v[W-1:0]);
          end
        end
      end
      acc = reqValid & reqReady;
      if (reqReady != '0) begin
        check("grant_onehot", $countones(reqReady), 1);
        check("grant_to_valid", 32'(acc), 32'(reqReady));
      end
      for (int i = 0; i < N; i++) if (acc[i]) grant_cnt[i]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    reqA[i*W +: W] = a;
    reqB[i*W +: W] = b;
    reqOp[i]       = op;
    reqValid[i]    = 1'b1;
  endtask

  // Waits (bounded) for requester i to be granted; returns just after the
  // accepting edge, with the number of cycles waited and the grant cycle.
  task automatic wait_grant(input int i, output int waited, output int at_cyc);
    bit ok;
    ok = 0;
    waited = 0;
    at_cyc = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      waited++;
      if (reqReady[i] && reqValid[i]) begin
        ok = 1;
        at_cyc = cyc;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL grant_timeout: requester %0d not granted within 50 cycles", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy && !rspValid) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b rspValid=%0b after 50 cycles", busy, rspValid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int w, t, g1_before;
  int gcyc [6];
  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
    rst      = 1'b1;
    reqValid = '1;
    reqA     = '0;
    reqB     = '0;
    reqOp    = '0;
    rspReady = 1'b1;

    // Reset state, with requests pending to show reqReady stays low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_reqReady",    32'(reqReady), 0);
    check("rst_rspValid",    32'(rspValid), 0);
    check("rst_busy",        32'(busy), 0);
    check("rst_rspResult",   32'(rspResult), 0);
    check("rst_rspId",       32'(rspId), 0);
    check("rst_rspOverflow", 32'(rspOverflow), 0);
    check("rst_state",       32'(dbg_state), 0);
    @(posedge clk);
    #1;
    reqValid = '0;
    rst = 1'b0;

    // Single request 3+4 with latency check.
    push_exp(0, 1'b0, 4'd7);
    set_req(0, 4'd3, 4'd4, 1'b0);
    wait_grant(0, w, t);
    check("single_first_cycle_grant", 32'(w), 1);
    reqValid[0] = 1'b0;
    @(negedge clk);
    check("lat_exec_rspValid", 32'(rspValid), 0);
    check("lat_exec_busy",     32'(busy), 1);
    check("lat_exec_reqReady", 32'(reqReady), 0);
    @(negedge clk);
    check("lat_resp_rspValid", 32'(rspValid), 1);
    wait_idle();

    // Overflow corner vectors.
    push_exp(0, 1'b1, 4'd8);
    set_req(0, 4'd7, 4'd1, 1'b0);
    wait_grant(0, w, t); reqValid[0] = 1'b0; wait_idle();
    push_exp(0, 1'b1, 4'd7);
    set_req(0, 4'd8, 4'd1, 1'b1);
    wait_grant(0, w, t); reqValid[0] = 1'b0; wait_idle();
    push_exp(0, 1'b1, 4'd8);
    set_req(0, 4'd0, 4'd8, 1'b1);
    wait_grant(0, w, t); reqValid[0] = 1'b0; wait_idle();
    push_exp(0, 1'b0, 4'd14);
    set_req(0, 4'd15, 4'd15, 1'b0);
    wait_grant(0, w, t); reqValid[0] = 1'b0; wait_idle();
    push_exp(1, 1'b0, 4'd15);
    set_req(1, 4'd3, 4'd4, 1'b1);
    wait_grant(1, w, t); reqValid[1] = 1'b0; wait_idle();

    // Fairness: all four held, grants 0,1,2,3,0,1 spaced 3 cycles.
    do_reset();
    for (int k = 0; k < 6; k++) push_exp(order[k], 1'b0, W'(order[k] + 1));
    for (int i = 0; i < N; i++) set_req(i, W'(i), 4'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      wait_grant(order[k], w, gcyc[k]);
      if (k == 0) check("fair_first_grant_immediate", 32'(w), 1);
      else        check("fair_spacing", 32'(gcyc[k] - gcyc[k-1]), 3);
    end
    reqValid = '0;
    wait_idle();

    // Backpressure: hold RESP for several cycles, req0 pending meanwhile.
    rspReady = 1'b0;
    push_exp(3, 1'b0, 4'd3);
    push_exp(0, 1'b0, 4'd2);
    set_req(3, 4'd5, 4'd2, 1'b1);
    wait_grant(3, w, t);
    reqValid[3] = 1'b0;
    set_req(0, 4'd1, 4'd1, 1'b0);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rspValid",  32'(rspValid), 1);
      check("bp_rspResult", 32'(rspResult), 3);
      check("bp_rspId",     32'(rspId), 3);
      check("bp_reqReady",  32'(reqReady), 0);
    end
    @(posedge clk);
    #1;
    rspReady = 1'b1;
    @(negedge clk);
    check("bp_handshake_reqReady", 32'(reqReady), 0);
    @(negedge clk);
    check("bp_after_busy",     32'(busy), 0);
    check("bp_after_rspValid", 32'(rspValid), 0);
    check("bp_after_reqReady", 32'(reqReady), 32'b0001);
    @(posedge clk);
    #1;
    reqValid[0] = 1'b0;
    wait_idle();

    // Reset while req2 executes: discarded, then req2 granted first again.
    do_reset();
    set_req(2, 4'd6, 4'd3, 1'b0);
    set_req(3, 4'd9, 4'd4, 1'b1);
    wait_grant(2, w, t);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_reqReady_in_rst", 32'(reqReady), 0);
    @(negedge clk);
    check("midrst_rspValid", 32'(rspValid), 0);
    check("midrst_busy",     32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(2, 1'b1, 4'd9);
    wait_grant(2, w, t);
    check("midrst_first_grant_req2", 32'(w), 1);
    reqValid[2] = 1'b0;
    push_exp(3, 1'b1, 4'd5);
    wait_grant(3, w, t);
    reqValid[3] = 1'b0;
    wait_idle();

    // Withdrawal: req1 pulses one cycle during req0's RESP, never served.
    rspReady = 1'b0;
    g1_before = grant_cnt[1];
    push_exp(0, 1'b0, 4'd4);
    set_req(0, 4'd2, 4'd2, 1'b0);
    wait_grant(0, w, t);
    reqValid[0] = 1'b0;
    @(posedge clk);
    #1;
    set_req(1, 4'd1, 4'd1, 1'b0);
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    rspReady = 1'b1;
    wait_idle();
    repeat (6) @(posedge clk);
    #1;
    check("withdraw_req1_grants", 32'(grant_cnt[1] - g1_before), 0);
    check("withdraw_busy", 32'(busy), 0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
